// File: rtl/rob_rollback_pkg.sv
// Shared types and defaults for the reorder buffer.
package rob_rollback_pkg;

  localparam int DEF_DEPTH = 8;
  localparam int DEF_WIDTH = 2;

  typedef logic [((DEF_DEPTH > 1) ? $clog2(DEF_DEPTH) : 1)-1:0] ROB_IDX;

  typedef struct packed {
    logic [31:0] pc;
    logic [5:0]  dest;
    logic        is_branch;
  } ROB_ENTRY_PACKET;

endpackage

// File: rtl/rob_rollback_ptr_adv.sv
// Circular pointer advance: sum_o = (ptr_i + delta_i) mod DEPTH.
// DEPTH need not be a power of two, so the wrap is a single conditional
// subtract; callers keep ptr_i < DEPTH and delta_i <= DEPTH.
module rob_ptr_adv #(
    parameter int DEPTH = 8,
    parameter int IDX_W = 3,
    parameter int D_W   = 4
) (
    input  logic [IDX_W-1:0] ptr_i,
    input  logic [D_W-1:0]   delta_i,
    output logic [IDX_W-1:0] sum_o
);
    localparam int S_W = ((IDX_W > D_W) ? IDX_W : D_W) + 1;

    logic [S_W-1:0] raw;

    // Add with wide headroom, then fold back once into [0, DEPTH).
    always_comb begin
        raw = S_W'(ptr_i) + S_W'(delta_i);
        if (raw >= S_W'(DEPTH)) raw = raw - S_W'(DEPTH);
        sum_o = raw[IDX_W-1:0];
    end

endmodule

// File: rtl/rob_rollback.sv
// Reorder buffer with multi-port completion, in-order retire and
// single-cycle tail rollback on mispredict.
// Optional: define ROB_CMPL_BYPASS_EN to let same-cycle completions show
// up on head_done so an entry can retire in the cycle it completes.
module rob_rollback
    import rob_rollback_pkg::*;
#(
    parameter  int DEPTH      = DEF_DEPTH,
    parameter  int WIDTH      = DEF_WIDTH,
    parameter  int CMPL_PORTS = DEF_WIDTH,
    localparam int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W      = $clog2(DEPTH + 1),
    localparam int W_W        = $clog2(WIDTH + 1)
) (
    input  logic                                clock,
    input  logic                                reset,
    input  ROB_ENTRY_PACKET [WIDTH-1:0]         disp_entries,
    input  logic [W_W-1:0]                      disp_count,
    output logic [W_W-1:0]                      spots,
    output logic [IDX_W-1:0]                    tail_idx,
    input  logic [CMPL_PORTS-1:0]               cmpl_valid,
    input  logic [CMPL_PORTS-1:0][IDX_W-1:0]    cmpl_idx,
    output ROB_ENTRY_PACKET [WIDTH-1:0]         head_entries,
    output logic [W_W-1:0]                      head_valid,
    output logic [WIDTH-1:0]                    head_done,
    input  logic [W_W-1:0]                      retire_count,
    input  logic                                squash,
    input  logic [IDX_W-1:0]                    squash_idx,
    output logic [CNT_W-1:0]                    num_entries
);

    // Architectural state
    logic [IDX_W-1:0]  head_q, head_d;
    logic [IDX_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DEPTH-1:0]  done_q, done_d;
    ROB_ENTRY_PACKET   entries_q [DEPTH];

    // Pointer arithmetic results
    logic [WIDTH-1:0][IDX_W-1:0]      hslot;      // head + i
    logic [WIDTH-1:0][IDX_W-1:0]      tslot;      // tail + i
    logic [IDX_W-1:0]                 head_nxt;   // head + retire_count
    logic [IDX_W-1:0]                 tail_disp;  // tail + disp_count
    logic [IDX_W-1:0]                 tail_sq;    // squash_idx + 1
    logic [CNT_W-1:0]                 neg_head;   // DEPTH - head, used to form ages
    logic [IDX_W-1:0]                 sq_age;     // squash_idx - head (mod DEPTH)
    logic [CMPL_PORTS-1:0][IDX_W-1:0] cmpl_age;   // cmpl_idx - head (mod DEPTH)
    logic [CMPL_PORTS-1:0]            cmpl_ok;
    logic [CNT_W-1:0]                 free_cnt;

    assign neg_head = CNT_W'(DEPTH) - CNT_W'(head_q);

    rob_ptr_adv #(.DEPTH(DEPTH), .IDX_W(IDX_W), .D_W(W_W)) u_head_nxt (
        .ptr_i(head_q), .delta_i(retire_count), .sum_o(head_nxt)
    );
    rob_ptr_adv #(.DEPTH(DEPTH), .IDX_W(IDX_W), .D_W(W_W)) u_tail_nxt (
        .ptr_i(tail_q), .delta_i(disp_count), .sum_o(tail_disp)
    );
    rob_ptr_adv #(.DEPTH(DEPTH), .IDX_W(IDX_W), .D_W(1)) u_sq_tail (
        .ptr_i(squash_idx), .delta_i(1'b1), .sum_o(tail_sq)
    );
    rob_ptr_adv #(.DEPTH(DEPTH), .IDX_W(IDX_W), .D_W(CNT_W)) u_sq_age (
        .ptr_i(squash_idx), .delta_i(neg_head), .sum_o(sq_age)
    );

    for (genvar i = 0; i < WIDTH; i++) begin : g_slot
        rob_ptr_adv #(.DEPTH(DEPTH), .IDX_W(IDX_W), .D_W(W_W)) u_hslot (
            .ptr_i(head_q), .delta_i(W_W'(i)), .sum_o(hslot[i])
        );
        rob_ptr_adv #(.DEPTH(DEPTH), .IDX_W(IDX_W), .D_W(W_W)) u_tslot (
            .ptr_i(tail_q), .delta_i(W_W'(i)), .sum_o(tslot[i])
        );
    end

    for (genvar p = 0; p < CMPL_PORTS; p++) begin : g_cmpl
        rob_ptr_adv #(.DEPTH(DEPTH), .IDX_W(IDX_W), .D_W(CNT_W)) u_age (
            .ptr_i(cmpl_idx[p]), .delta_i(neg_head), .sum_o(cmpl_age[p])
        );
        // Completion only lands on an occupied entry that survives any squash.
        assign cmpl_ok[p] = cmpl_valid[p]
                          && (CNT_W'(cmpl_age[p]) < count_q)
                          && (!squash || (cmpl_age[p] <= sq_age));
    end

    // Dispatch credit and head window size come from registered occupancy only.
    always_comb begin
        free_cnt    = CNT_W'(DEPTH) - count_q;
        spots       = (free_cnt < CNT_W'(WIDTH)) ? W_W'(free_cnt) : W_W'(WIDTH);
        head_valid  = (count_q < CNT_W'(WIDTH)) ? W_W'(count_q) : W_W'(WIDTH);
        tail_idx    = tail_q;
        num_entries = count_q;
    end

    // Head window: payload and done flags for the oldest WIDTH entries.
    always_comb begin
        logic hit;
        head_entries = '0;
        head_done    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            head_entries[i] = entries_q[hslot[i]];
            hit = done_q[hslot[i]];
`ifdef ROB_CMPL_BYPASS_EN
            for (int p = 0; p < CMPL_PORTS; p++) begin
                if (cmpl_valid[p] && (cmpl_idx[p] == hslot[i])) hit = 1'b1;
            end
`endif
            head_done[i] = hit && (i < int'(head_valid));
        end
    end

    // Next-state pointers/occupancy; squash overrides dispatch but not retire.
    always_comb begin
        head_d = head_nxt;
        if (squash) begin
            tail_d  = tail_sq;
            count_d = CNT_W'(sq_age) + CNT_W'(1) - CNT_W'(retire_count);
        end else begin
            tail_d  = tail_disp;
            count_d = count_q + CNT_W'(disp_count) - CNT_W'(retire_count);
        end
    end

    // Done flags: completions set, newly dispatched slots clear.
    always_comb begin
        done_d = done_q;
        for (int p = 0; p < CMPL_PORTS; p++) begin
            if (cmpl_ok[p]) done_d[cmpl_idx[p]] = 1'b1;
        end
        if (!squash) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (i < int'(disp_count)) done_d[tslot[i]] = 1'b0;
            end
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            done_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    // Payload storage; never reset, only written on accepted dispatch.
    always_ff @(posedge clock) begin
        for (int i = 0; i < WIDTH; i++) begin
            if (!squash && (i < int'(disp_count))) entries_q[tslot[i]] <= disp_entries[i];
        end
    end

`ifndef SYNTHESIS
    int lead_done;

    // Count of consecutive done entries from the head, bounding retire.
    always_comb begin
        logic stop;
        lead_done = 0;
        stop      = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (!stop && head_done[i]) lead_done = lead_done + 1;
            else                       stop      = 1'b1;
        end
    end

    // Flag protocol violations from dispatch, retire and branch recovery.
    always @(posedge clock) begin
        if (!reset) begin
            assert (squash || (disp_count <= spots))
                else $error("rob_rollback: dispatch exceeds free spots");
            assert (int'(retire_count) <= lead_done)
                else $error("rob_rollback: retire of entry not done");
            if (squash) begin
                assert (CNT_W'(sq_age) < count_q)
                    else $error("rob_rollback: squash_idx not occupied");
                assert (int'(retire_count) <= int'(sq_age) + 1)
                    else $error("rob_rollback: retire beyond squash point");
            end
        end
    end
`endif

endmodule

// File: tb/tb_rob_rollback.sv
// Directed bench for rob_rollback (DEPTH=8, WIDTH=2, CMPL_PORTS=2).
// A queue-based model tracks in-flight entries; outputs are compared every
// cycle, with literal expectations pinning key points of each scenario.
module tb_rob_rollback;
    import rob_rollback_pkg::*;

    localparam int D = 8, W = 2, CP = 2;
    localparam int IDX_W = 3, CNT_W = 4, W_W = 2;

    logic                        clock = 1'b0;
    logic                        reset;
    ROB_ENTRY_PACKET [W-1:0]     disp_entries;
    logic [W_W-1:0]              disp_count;
    logic [W_W-1:0]              spots;
    logic [IDX_W-1:0]            tail_idx;
    logic [CP-1:0]               cmpl_valid;
    logic [CP-1:0][IDX_W-1:0]    cmpl_idx;
    ROB_ENTRY_PACKET [W-1:0]     head_entries;
    logic [W_W-1:0]              head_valid;
    logic [W-1:0]                head_done;
    logic [W_W-1:0]              retire_count;
    logic                        squash;
    logic [IDX_W-1:0]            squash_idx;
    logic [CNT_W-1:0]            num_entries;

    int ncmp  = 0;
    int nfail = 0;
    int seq   = 0;
    int mhead = 0;

    typedef struct { ROB_ENTRY_PACKET pkt; bit done; } mrec_t;
    mrec_t q[$];

    rob_rollback #(.DEPTH(D), .WIDTH(W), .CMPL_PORTS(CP)) dut (
        .clock(clock), .reset(reset),
        .disp_entries(disp_entries), .disp_count(disp_count), .spots(spots),
        .tail_idx(tail_idx), .cmpl_valid(cmpl_valid), .cmpl_idx(cmpl_idx),
        .head_entries(head_entries), .head_valid(head_valid), .head_done(head_done),
        .retire_count(retire_count), .squash(squash), .squash_idx(squash_idx),
        .num_entries(num_entries)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic ROB_ENTRY_PACKET mk(input int s);
        ROB_ENTRY_PACKET e;
        e.pc        = 32'h100 + 32'(s);
        e.dest      = 6'(s);
        e.is_branch = (s % 3 == 0);
        return e;
    endfunction

    task automatic drive(input int dc, input int v0, input int i0, input int v1, input int i1,
                         input int rc, input int sq, input int sqi);
        disp_count = W_W'(dc);
        for (int i = 0; i < W; i++) begin
            if (i < dc) disp_entries[i] = mk(seq + i);
            else        disp_entries[i] = '{pc: 32'hdead0000, dest: 6'h3f, is_branch: 1'b1};
        end
        if (sq == 0) seq = seq + dc;
        cmpl_valid   = {v1[0], v0[0]};
        cmpl_idx[0]  = IDX_W'(i0);
        cmpl_idx[1]  = IDX_W'(i1);
        retire_count = W_W'(rc);
        squash       = sq[0];
        squash_idx   = IDX_W'(sqi);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Expected outputs from the model of the entries currently held.
    task automatic check_outputs();
        int sz, hv, sp;
        logic [W-1:0] ehd;
        sz  = q.size();
        hv  = (sz < W) ? sz : W;
        sp  = ((D - sz) < W) ? (D - sz) : W;
        ehd = '0;
        for (int i = 0; i < hv; i++) begin
            ehd[i] = q[i].done;
`ifdef ROB_CMPL_BYPASS_EN
            for (int p = 0; p < CP; p++)
                if (cmpl_valid[p] && (int'(cmpl_idx[p]) == (mhead + i) % D)) ehd[i] = 1'b1;
`endif
        end
        chk("spots",       64'(spots),       64'(sp));
        chk("tail_idx",    64'(tail_idx),    64'((mhead + sz) % D));
        chk("head_valid",  64'(head_valid),  64'(hv));
        chk("num_entries", 64'(num_entries), 64'(sz));
        chk("head_done",   64'(head_done),   64'(ehd));
        for (int i = 0; i < hv; i++)
            chk($sformatf("head_entry%0d", i), 64'(head_entries[i]), 64'(q[i].pkt));
    endtask

    // Apply one clock edge's worth of inputs to the model.
    task automatic model_step();
        int age, k;
        mrec_t t;
        age = (int'(squash_idx) - mhead + D) % D;
        for (int p = 0; p < CP; p++) begin
            if (cmpl_valid[p]) begin
                k = (int'(cmpl_idx[p]) - mhead + D) % D;
                if (k < q.size() && (!squash || k <= age)) begin
                    t = q[k]; t.done = 1'b1; q[k] = t;
                end
            end
        end
        if (squash) while (q.size() > age + 1) q.delete(q.size() - 1);
        for (int r = 0; r < int'(retire_count); r++) q.delete(0);
        mhead = (mhead + int'(retire_count)) % D;
        if (!squash) begin
            for (int i = 0; i < int'(disp_count); i++) begin
                t.pkt = disp_entries[i]; t.done = 1'b0;
                q.push_back(t);
            end
        end
    endtask

    task automatic cyc();
        @(negedge clock);
        check_outputs();
        @(posedge clock);
        model_step();
        #1;
        idle();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        #1;
        chk("rst_spots",      64'(spots),       64'd2);
        chk("rst_head_valid", 64'(head_valid),  64'd0);
        chk("rst_num",        64'(num_entries), 64'd0);
        chk("rst_head_done",  64'(head_done),   64'd0);
        chk("rst_tail",       64'(tail_idx),    64'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // Fill to full: tail wraps back to 0.
        for (int c = 0; c < 4; c++) begin drive(2, 0, 0, 0, 0, 0, 0, 0); cyc(); end
        chk("full_num",   64'(num_entries), 64'd8);
        chk("full_spots", 64'(spots),       64'd0);
        chk("full_tail",  64'(tail_idx),    64'd0);

        // Complete 0,1 then retire them; refill behind the head.
        drive(0, 1, 0, 1, 1, 0, 0, 0); cyc();
        chk("done01", 64'(head_done), 64'd3);
        drive(0, 0, 0, 0, 0, 2, 0, 0); cyc();
        chk("ret2_num",  64'(num_entries),     64'd6);
        chk("ret2_head", 64'(head_entries[0].pc), 64'h102);
        drive(2, 1, 2, 1, 3, 0, 0, 0); cyc();
        chk("refill_num", 64'(num_entries), 64'd8);
        chk("done23",     64'(head_done),   64'd3);
        drive(0, 0, 0, 0, 0, 2, 0, 0); cyc();
        drive(0, 1, 4, 1, 5, 0, 0, 0); cyc();
        drive(2, 0, 0, 0, 0, 2, 0, 0); cyc();       // retire and dispatch together
        chk("rd_num",  64'(num_entries),      64'd6);
        chk("rd_tail", 64'(tail_idx),         64'd4);
        chk("rd_head", 64'(head_entries[0].pc), 64'h106);
        cyc();

        // Reset asserted between edges takes effect immediately.
        @(negedge clock); #2 reset = 1'b1; #1;
        chk("mid_rst_spots", 64'(spots),       64'd2);
        chk("mid_rst_hv",    64'(head_valid),  64'd0);
        chk("mid_rst_num",   64'(num_entries), 64'd0);
        q.delete(); mhead = 0;
        @(posedge clock); #1 reset = 1'b0;

        // Six entries, out-of-order completion of idx 1 then 0.
        for (int c = 0; c < 3; c++) begin drive(2, 0, 0, 0, 0, 0, 0, 0); cyc(); end
        drive(0, 1, 1, 1, 1, 0, 0, 0); cyc();
        chk("done_10", 64'(head_done), 64'd2);
        drive(0, 1, 0, 0, 0, 0, 0, 0); cyc();
        chk("done_11", 64'(head_done), 64'd3);

        // Squash at 2 with ignored dispatch and a squashed completion.
        drive(2, 1, 4, 0, 0, 0, 1, 2); cyc();
        chk("sq_num",  64'(num_entries), 64'd3);
        chk("sq_tail", 64'(tail_idx),    64'd3);
        drive(2, 0, 0, 0, 0, 0, 0, 0); cyc();

        // Squash at 3 while retiring the head; completion of idx 5 is squashed.
        drive(0, 1, 5, 0, 0, 1, 1, 3); cyc();
        chk("sqr_num",  64'(num_entries), 64'd3);
        chk("sqr_tail", 64'(tail_idx),    64'd4);
        chk("sqr_done", 64'(head_done),   64'd1);
        drive(0, 1, 2, 0, 0, 1, 0, 0); cyc();       // completes idx 2 at head+1
        drive(0, 0, 0, 0, 0, 1, 1, 2); cyc();       // squash on head, retire it: empty
        chk("empty_num",  64'(num_entries), 64'd0);
        chk("empty_hv",   64'(head_valid),  64'd0);
        chk("empty_done", 64'(head_done),   64'd0);
        chk("empty_tail", 64'(tail_idx),    64'd3);

        // Wrap-around fill, then squash across the wrap point.
        for (int c = 0; c < 4; c++) begin drive(2, 0, 0, 0, 0, 0, 0, 0); cyc(); end
        chk("wrap_tail", 64'(tail_idx),    64'd3);
        chk("wrap_num",  64'(num_entries), 64'd8);
        drive(0, 1, 7, 1, 1, 0, 1, 0); cyc();
        chk("wsq_tail", 64'(tail_idx),    64'd1);
        chk("wsq_num",  64'(num_entries), 64'd6);
        drive(0, 1, 3, 1, 4, 0, 0, 0); cyc();
        drive(2, 0, 0, 0, 0, 2, 0, 0); cyc();
        cyc();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
